emergency_preempt_ctrl: RTL and testbench

Emergency preemption controller that feeds the traffic-signal top level. It takes the four raw emergency-request switches (one per approach) and produces the emergency signal position, position-select, hold and emergency-LED signals. The top level muxes these over the normal phase sequencer. Timing is paced by a single-cycle 4 Hz tick enable, and all logic runs on one clock.

---
 rtl/emergency_preempt_if.sv | 13 +
 rtl/emergency_preempt_ctrl.sv | 78 +++++++
 tb/tb_emergency_preempt_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/emergency_preempt_if.sv
// emergency_preempt_if: tick, request and emergency-position signals between the controller and the signal top level
interface emergency_preempt_if;
  logic       tick;
  logic [3:0] em_sw;
  logic [1:0] cur_pos;
  logic [1:0] em_pos;
  logic       pos_select;
  logic       hold;
  logic       all_red;
  logic       em_led;
  modport master(output tick, em_sw, cur_pos, input em_pos, pos_select, hold, all_red, em_led);
  modport slave(input tick, em_sw, cur_pos, output em_pos, pos_select, hold, all_red, em_led);
endinterface

// File: rtl/emergency_preempt_ctrl.sv
// emergency_preempt_ctrl: debounced round-robin emergency preemption over the normal phase sequencer
module emergency_preempt_ctrl #(
  parameter int DEB_TICKS = 4,
  parameter int CLEAR_TICKS = 8,
  parameter int MIN_SERVE_TICKS = 12,
  parameter int RELEASE_TICKS = 8,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic rst,
  emergency_preempt_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CLEAR, SERVE, RELEASE} state_t;
  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEB_TICKS);
  state_t state, state_n;
  logic [3:0] sync1, sync2, req_valid;
  logic [3:0][CNT_W-1:0] deb;
  logic [CNT_W-1:0] timer;
  logic [1:0] grant, last_served, pick;
  logic pos_select, hold, all_red, em_led;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb <= '0;
    end else begin
      sync1 <= bus.em_sw;
      sync2 <= sync1;
      if (bus.tick)
        for (int k = 0; k < 4; k++)
          deb[k] <= !sync2[k] ? '0 : deb[k] == DEB ? deb[k] : deb[k] + CNT_W'(1);
    end
  always_comb begin
    req_valid = '0;
    for (int k = 0; k < 4; k++) req_valid[k] = deb[k] == DEB;
  end
  // walk downward so the candidate closest after last_served wins
  always_comb begin
    pick = grant;
    for (int k = 4; k >= 1; k--)
      if (req_valid[last_served + 2'(k)]) pick = last_served + 2'(k);
  end
  always_comb begin
    state_n = state;
    if (bus.tick)
      case (state)
        IDLE:    if (|req_valid) state_n = pick == bus.cur_pos ? SERVE : CLEAR;
        CLEAR:   if (timer == CNT_W'(CLEAR_TICKS - 1)) state_n = SERVE;
        SERVE:   if (timer >= CNT_W'(MIN_SERVE_TICKS - 1) && !req_valid[grant]) state_n = RELEASE;
        default: if (timer == CNT_W'(RELEASE_TICKS - 1)) state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      grant <= '0;
      last_served <= 2'd3;
      pos_select <= 1'b0;
      hold <= 1'b0;
      all_red <= 1'b0;
      em_led <= 1'b0;
    end else begin
      state <= state_n;
      if (bus.tick) timer <= state_n != state ? '0 : &timer ? timer : timer + CNT_W'(1);
      if (state == IDLE && state_n != IDLE) grant <= pick;
      if (state == RELEASE && state_n == IDLE) last_served <= grant;
      pos_select <= state_n != IDLE;
      hold <= state_n != IDLE;
      all_red <= state_n == CLEAR || state_n == RELEASE;
      em_led <= state_n == IDLE ? 1'b0 : em_led ^ bus.tick;
    end
  assign bus.em_pos = grant;
  assign bus.pos_select = pos_select;
  assign bus.hold = hold;
  assign bus.all_red = all_red;
  assign bus.em_led = em_led;
endmodule

// File: tb/tb_emergency_preempt_ctrl.sv
// tb_emergency_preempt_ctrl: vector table, corner sequences and random run against a tick-level reference model
module tb_emergency_preempt_ctrl;
  localparam int DEB = 4, CLR = 8, MSV = 12, REL = 8;
  logic clk = 1'b0;
  logic rst;
  int total = 0, bad = 0, cyc_n = 0;
  always #5 clk = ~clk;
  emergency_preempt_if bus();
  emergency_preempt_ctrl dut(.clk(clk), .rst(rst), .bus(bus));

  // phases: 0 idle, 1 clearance, 2 serving, 3 recovery; m_cnt = ticks spent in phase
  int m_run[4];
  int m_phase, m_cnt, m_g, m_last;
  bit m_led;
  logic [3:0] hist[$];

  typedef struct {
    logic [3:0] sw;
    logic [1:0] cur;
    int n;
    logic ps;
    logic ar;
    logic [1:0] pos;
  } vec_t;
  vec_t tbl[15];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_phase = 0; m_cnt = 0; m_g = 0; m_last = 3; m_led = 0;
    hist = '{4'b0, 4'b0};
  endtask

  task automatic model_step();
    logic [3:0] s;
    bit v[4];
    s = hist.pop_front();
    hist.push_back(bus.em_sw);
    for (int i = 0; i < 4; i++) v[i] = m_run[i] >= DEB;
    if (bus.tick) begin
      if (m_phase == 0) begin
        for (int k = 1; k <= 4; k++)
          if (m_phase == 0 && v[(m_last + k) % 4]) begin
            m_g = (m_last + k) % 4;
            m_phase = (m_g == int'(bus.cur_pos)) ? 2 : 1;
            m_cnt = 0;
            m_led = 1;
          end
      end else begin
        m_led = !m_led;
        m_cnt++;
        if (m_phase == 1 && m_cnt == CLR) begin m_phase = 2; m_cnt = 0; end
        else if (m_phase == 2 && m_cnt >= MSV && !v[m_g]) begin m_phase = 3; m_cnt = 0; end
        else if (m_phase == 3 && m_cnt == REL) begin m_phase = 0; m_last = m_g; m_led = 0; end
      end
      for (int i = 0; i < 4; i++) m_run[i] = s[i] ? m_run[i] + 1 : 0;
    end
  endtask

  function automatic logic [5:0] exp_vec();
    logic act = m_phase != 0;
    return {2'(m_g), act, act, m_phase == 1 || m_phase == 3, m_led};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("model", {bus.em_pos, bus.pos_select, bus.hold, bus.all_red, bus.em_led}, exp_vec());
  endtask

  task automatic run(int n, int per);
    for (int i = 0; i < n; i++) begin
      bus.tick = (cyc_n % per) == 0;
      cyc_n++;
      cyc();
    end
  endtask

  task automatic wait_state(logic ps, logic ar, int max, string name);
    int k = 0;
    while (!(bus.pos_select === ps && bus.all_red === ar) && k < max) begin
      run(1, 1);
      k++;
    end
    check(name, {bus.pos_select, bus.all_red}, {ps, ar});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.em_sw = '0;
    bus.cur_pos = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc_n = 0;
  endtask

  initial begin
    int n, seen;
    tbl[0]  = '{4'b0100, 2'd0, 6,  1'b0, 1'b0, 2'd0};
    tbl[1]  = '{4'b0100, 2'd0, 1,  1'b1, 1'b1, 2'd2};
    tbl[2]  = '{4'b0100, 2'd0, 7,  1'b1, 1'b1, 2'd2};
    tbl[3]  = '{4'b0100, 2'd0, 1,  1'b1, 1'b0, 2'd2};
    tbl[4]  = '{4'b0100, 2'd0, 20, 1'b1, 1'b0, 2'd2};
    tbl[5]  = '{4'b0000, 2'd0, 3,  1'b1, 1'b0, 2'd2};
    tbl[6]  = '{4'b0000, 2'd0, 1,  1'b1, 1'b1, 2'd2};
    tbl[7]  = '{4'b0000, 2'd0, 7,  1'b1, 1'b1, 2'd2};
    tbl[8]  = '{4'b0000, 2'd0, 1,  1'b0, 1'b0, 2'd2};
    tbl[9]  = '{4'b0010, 2'd1, 6,  1'b0, 1'b0, 2'd2};
    tbl[10] = '{4'b0000, 2'd1, 1,  1'b1, 1'b0, 2'd1};
    tbl[11] = '{4'b0000, 2'd1, 11, 1'b1, 1'b0, 2'd1};
    tbl[12] = '{4'b0000, 2'd1, 1,  1'b1, 1'b1, 2'd1};
    tbl[13] = '{4'b0000, 2'd1, 7,  1'b1, 1'b1, 2'd1};
    tbl[14] = '{4'b0000, 2'd1, 1,  1'b0, 1'b0, 2'd1};

    do_reset();
    check("reset pos_select", bus.pos_select, 0);
    check("reset hold", bus.hold, 0);
    check("reset all_red", bus.all_red, 0);
    check("reset em_led", bus.em_led, 0);
    check("reset em_pos", bus.em_pos, 0);

    // basic preempt then skip-clearance, tick tied high
    foreach (tbl[i]) begin
      bus.em_sw = tbl[i].sw;
      bus.cur_pos = tbl[i].cur;
      run(tbl[i].n, 1);
      check($sformatf("tbl%0d pos_select", i), bus.pos_select, tbl[i].ps);
      check($sformatf("tbl%0d hold", i), bus.hold, tbl[i].ps);
      check($sformatf("tbl%0d all_red", i), bus.all_red, tbl[i].ar);
      check($sformatf("tbl%0d em_pos", i), bus.em_pos, tbl[i].pos);
    end

    // debounce reject: 3 ticks high at one tick per 4 clk
    do_reset();
    seen = 0;
    bus.em_sw = 4'b0100;
    for (int i = 0; i < 12; i++) begin run(1, 4); seen |= int'(bus.pos_select); end
    bus.em_sw = '0;
    for (int i = 0; i < 24; i++) begin run(1, 4); seen |= int'(bus.pos_select); end
    check("deb reject", seen, 0);

    // round robin from reset, then the still-valid bit 3 on the single IDLE tick
    do_reset();
    bus.em_sw = 4'b1001;
    bus.cur_pos = 2'd2;
    wait_state(1, 1, 40, "rr first clear");
    check("rr first grant", bus.em_pos, 0);
    bus.em_sw = 4'b1000;
    wait_state(0, 0, 200, "rr idle");
    run(1, 1);
    check("rr next active", bus.pos_select, 1);
    check("rr next grant", bus.em_pos, 3);

    // request dropped during clearance
    do_reset();
    bus.em_sw = 4'b1000;
    wait_state(1, 1, 40, "drop clear start");
    run(2, 1);
    bus.em_sw = '0;
    n = 3;
    while (n < 50) begin
      run(1, 1);
      if (bus.pos_select && bus.all_red) n++; else break;
    end
    check("drop clear len", n, CLR);
    n = 1;
    while (n < 50) begin
      run(1, 1);
      if (bus.pos_select && !bus.all_red) n++; else break;
    end
    check("drop serve len", n, MSV);
    check("drop release", {bus.pos_select, bus.all_red}, 2'b11);

    // async reset in the middle of serving
    do_reset();
    bus.em_sw = 4'b0100;
    wait_state(1, 0, 60, "arst serve");
    #2 rst = 1'b1;
    #1;
    check("arst pos_select", bus.pos_select, 0);
    check("arst hold", bus.hold, 0);
    check("arst all_red", bus.all_red, 0);
    check("arst em_led", bus.em_led, 0);
    model_reset();
    bus.em_sw = 4'b0011;
    bus.cur_pos = 2'd3;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_state(1, 1, 40, "arst regrant");
    check("arst grant", bus.em_pos, 0);

    // random switches, cur_pos and tick pacing
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) bus.em_sw[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 99) == 0) bus.cur_pos = 2'($urandom_range(0, 3));
      bus.tick = $urandom_range(0, 2) == 0;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
